// File: rtl/exc_pkg.sv
// Shared exception-sequencer types: FSM states, cause codes and the PC-mux select
// encodings that the main control FSM also uses.
package exc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SAVE  = 3'd1,
    FETCH = 3'd2,
    LOAD  = 3'd3,
    DONE  = 3'd4
  } exc_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_OPC  = 2'b01,
    CAUSE_OVF  = 2'b10,
    CAUSE_DIV0 = 2'b11
  } exc_cause_e;

  localparam logic [2:0] PC_SEL_MEMVEC = 3'b101;
  localparam logic [2:0] PC_SEL_PC4    = 3'b000;

  // Simultaneous requests resolve as opcode > overflow > divide-by-zero.
  function automatic exc_cause_e pick_cause(input logic opc, input logic ovf, input logic div0);
    if (opc)       return CAUSE_OPC;
    else if (ovf)  return CAUSE_OVF;
    else if (div0) return CAUSE_DIV0;
    else           return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/exc_wait_cnt.sv
// 4-bit loadable down counter that times the memory-read wait in FETCH.
module exc_wait_cnt (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic [3:0] count_o,
  output logic       zero_o
);

  logic [3:0] cnt_q, cnt_d;

  // Load wins over decrement; the count saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && (cnt_q != 4'd0))
      cnt_d = cnt_q - 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_q <= 4'd0;
    else
      cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;
  assign zero_o  = (cnt_q == 4'd0);

endmodule

// File: rtl/exception_ctrl.sv
// Multicycle exception sequencer: saves EPC, fetches the handler vector byte and
// loads it into PC through the PC-source mux.
module exception_ctrl
  import exc_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned VEC_OPC = 253,
  parameter int unsigned VEC_OVF = 254,
  parameter int unsigned VEC_DIV = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_ovf,
  input  logic        exc_div0,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data_in,
  output logic [31:0] epc_out,
  output logic [31:0] vec_out,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic [2:0]  pc_src_sel,
  output logic        pc_write,
  output logic        exc_active,
  output logic        exc_done,
  output logic [1:0]  exc_cause
);

  localparam logic [3:0]  LAT_LOAD  = 4'(MEM_LAT);
  localparam logic [31:0] ADDR_OPC  = 32'(VEC_OPC);
  localparam logic [31:0] ADDR_OVF  = 32'(VEC_OVF);
  localparam logic [31:0] ADDR_DIV  = 32'(VEC_DIV);

  exc_state_e  state_q;
  exc_cause_e  cause_q;
  logic [31:0] epc_q;
  logic [31:0] vec_q;

  logic [3:0]  cnt_val;
  logic        cnt_zero;
  logic        fetch_last;
  logic        any_req;
  logic        unused_mem_hi;

  exc_wait_cnt u_wait_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (state_q == SAVE),
    .load_val_i (LAT_LOAD),
    .dec_i      (state_q == FETCH),
    .count_o    (cnt_val),
    .zero_o     (cnt_zero)
  );

  // A zero count in FETCH also ends the wait so the FSM can never stall there.
  assign fetch_last    = (state_q == FETCH) && ((cnt_val == 4'd1) || cnt_zero);
  assign any_req       = exc_opcode | exc_ovf | exc_div0;
  assign unused_mem_hi = ^mem_data_in[31:8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cause_q <= CAUSE_NONE;
      epc_q   <= 32'd0;
      vec_q   <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            cause_q <= pick_cause(exc_opcode, exc_ovf, exc_div0);
            state_q <= SAVE;
          end
        end
        SAVE: begin
          epc_q   <= pc_in - 32'd4;
          state_q <= FETCH;
        end
        FETCH: begin
          if (fetch_last) begin
            vec_q   <= {24'd0, mem_data_in[7:0]};
            state_q <= LOAD;
          end
        end
        LOAD:    state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_addr = 32'd0;
    if (state_q == FETCH) begin
      case (cause_q)
        CAUSE_OPC:  mem_addr = ADDR_OPC;
        CAUSE_OVF:  mem_addr = ADDR_OVF;
        CAUSE_DIV0: mem_addr = ADDR_DIV;
        default:    mem_addr = 32'd0;
      endcase
    end
  end

  assign epc_out    = epc_q;
  assign vec_out    = vec_q;
  assign exc_cause  = cause_q;
  assign mem_read   = (state_q == FETCH);
  assign pc_write   = (state_q == LOAD);
  assign pc_src_sel = (state_q == LOAD) ? PC_SEL_MEMVEC : PC_SEL_PC4;
  assign exc_active = (state_q != IDLE);
  assign exc_done   = (state_q == DONE);

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl: three instances with MEM_LAT = 1, 3 and 4.
module tb_exception_ctrl;

  logic clk;
  logic reset;

  logic        excOpcode [3];
  logic        excOvf    [3];
  logic        excDiv0   [3];
  logic [31:0] pcIn      [3];
  logic [31:0] memData   [3];
  logic [31:0] epcOut    [3];
  logic [31:0] vecOut    [3];
  logic [31:0] memAddr   [3];
  logic        memRead   [3];
  logic [2:0]  pcSrcSel  [3];
  logic        pcWrite   [3];
  logic        excActive [3];
  logic        excDone   [3];
  logic [1:0]  excCause  [3];

  int checkCount = 0;
  int passCount  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] memByte(input logic [31:0] addr);
    case (addr)
      32'd253: return 8'h61;
      32'd254: return 8'hA4;
      32'd255: return 8'hC7;
      default: return 8'h00;
    endcase
  endfunction

  // Each memory model returns valid data only on the last FETCH cycle, junk before.
  for (genvar g = 0; g < 3; g++) begin : gDut
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    int fetchCnt;

    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        fetchCnt <= 0;
      else if (memRead[g])
        fetchCnt <= fetchCnt + 1;
      else
        fetchCnt <= 0;
    end

    assign memData[g] = (memRead[g] && (fetchCnt == LAT - 1)) ?
                        {24'hABCDEF, memByte(memAddr[g])} : 32'h5A5A_5A5A;

    exception_ctrl #(.MEM_LAT(LAT)) dut (
      .clk         (clk),
      .reset       (reset),
      .exc_opcode  (excOpcode[g]),
      .exc_ovf     (excOvf[g]),
      .exc_div0    (excDiv0[g]),
      .pc_in       (pcIn[g]),
      .mem_data_in (memData[g]),
      .epc_out     (epcOut[g]),
      .vec_out     (vecOut[g]),
      .mem_addr    (memAddr[g]),
      .mem_read    (memRead[g]),
      .pc_src_sel  (pcSrcSel[g]),
      .pc_write    (pcWrite[g]),
      .exc_active  (excActive[g]),
      .exc_done    (excDone[g]),
      .exc_cause   (excCause[g])
    );
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected)
      passCount++;
    else
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
  endtask

  task automatic applyStimulus(input int idx, input logic opc, input logic ovf, input logic div0,
                               input logic [31:0] pc);
    excOpcode[idx] = opc;
    excOvf[idx]    = ovf;
    excDiv0[idx]   = div0;
    pcIn[idx]      = pc;
  endtask

  task automatic observeWindow(input int idx, input int cycles, output int nRead, output int nWrite,
                               output int nDone, output int firstDone);
    nRead = 0;
    nWrite = 0;
    nDone = 0;
    firstDone = -1;
    for (int c = 1; c <= cycles; c++) begin
      @(negedge clk);
      if (memRead[idx]) nRead++;
      if (pcWrite[idx]) nWrite++;
      if (excDone[idx]) begin
        nDone++;
        if (firstDone < 0) firstDone = c;
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nRead, nWrite, nDone, firstDone;

    reset = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(i, 1'b0, 1'b0, 1'b0, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("reset epc[%0d]", i), epcOut[i], 32'd0);
      checkOutput($sformatf("reset vec[%0d]", i), vecOut[i], 32'd0);
      checkOutput($sformatf("reset addr[%0d]", i), memAddr[i], 32'd0);
      checkOutput($sformatf("reset cause[%0d]", i), 32'(excCause[i]), 32'd0);
      checkOutput($sformatf("reset active[%0d]", i), 32'(excActive[i]), 32'd0);
      checkOutput($sformatf("reset read[%0d]", i), 32'(memRead[i]), 32'd0);
    end

    // Overflow with MEM_LAT=1, PC+4 = 0x40.
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 32'h40);
    @(negedge clk);
    checkOutput("ovf save active", 32'(excActive[0]), 32'd1);
    checkOutput("ovf cause", 32'(excCause[0]), 32'd2);
    checkOutput("ovf save read", 32'(memRead[0]), 32'd0);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h40);
    @(negedge clk);
    checkOutput("ovf fetch read", 32'(memRead[0]), 32'd1);
    checkOutput("ovf fetch addr", memAddr[0], 32'd254);
    checkOutput("ovf epc", epcOut[0], 32'h3C);
    checkOutput("ovf fetch no write", 32'(pcWrite[0]), 32'd0);
    @(negedge clk);
    checkOutput("ovf load read", 32'(memRead[0]), 32'd0);
    checkOutput("ovf load addr", memAddr[0], 32'd0);
    checkOutput("ovf load sel", 32'(pcSrcSel[0]), 32'd5);
    checkOutput("ovf load write", 32'(pcWrite[0]), 32'd1);
    checkOutput("ovf vec", vecOut[0], 32'hA4);
    @(negedge clk);
    checkOutput("ovf done", 32'(excDone[0]), 32'd1);
    checkOutput("ovf done write", 32'(pcWrite[0]), 32'd0);
    checkOutput("ovf done sel", 32'(pcSrcSel[0]), 32'd0);
    @(negedge clk);
    checkOutput("ovf idle done", 32'(excDone[0]), 32'd0);
    checkOutput("ovf idle active", 32'(excActive[0]), 32'd0);
    checkOutput("ovf cause held", 32'(excCause[0]), 32'd2);
    checkOutput("ovf epc held", epcOut[0], 32'h3C);
    checkOutput("ovf vec held", vecOut[0], 32'hA4);

    // Opcode and div0 together: opcode wins.
    applyStimulus(0, 1'b1, 1'b0, 1'b1, 32'h100);
    @(negedge clk);
    checkOutput("prio cause", 32'(excCause[0]), 32'd1);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h100);
    @(negedge clk);
    checkOutput("prio addr", memAddr[0], 32'd253);
    checkOutput("prio epc", epcOut[0], 32'hFC);
    observeWindow(0, 8, nRead, nWrite, nDone, firstDone);
    checkOutput("prio done count", 32'(nDone), 32'd1);
    checkOutput("prio no rerun", 32'(nRead), 32'd0);
    checkOutput("prio vec", vecOut[0], 32'h61);

    // div0 pulsed only during LOAD is dropped.
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 32'h200);
    @(negedge clk);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h200);
    @(negedge clk);
    @(negedge clk);
    checkOutput("pulse in load", 32'(pcWrite[0]), 32'd1);
    applyStimulus(0, 1'b0, 1'b0, 1'b1, 32'h200);
    @(negedge clk);
    checkOutput("pulse done", 32'(excDone[0]), 32'd1);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h200);
    observeWindow(0, 8, nRead, nWrite, nDone, firstDone);
    checkOutput("pulse extra done", 32'(nDone), 32'd0);
    checkOutput("pulse extra read", 32'(nRead), 32'd0);
    checkOutput("pulse cause", 32'(excCause[0]), 32'd2);

    // div0 held from LOAD through DONE restarts from IDLE; pc_in = 0 wraps EPC.
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 32'h300);
    @(negedge clk);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h300);
    @(negedge clk);
    @(negedge clk);
    applyStimulus(0, 1'b0, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    checkOutput("held done", 32'(excDone[0]), 32'd1);
    @(negedge clk);
    checkOutput("held idle", 32'(excActive[0]), 32'd0);
    @(negedge clk);
    checkOutput("held restart", 32'(excActive[0]), 32'd1);
    checkOutput("held cause", 32'(excCause[0]), 32'd3);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("wrap addr", memAddr[0], 32'd255);
    checkOutput("wrap epc", epcOut[0], 32'hFFFF_FFFC);
    @(negedge clk);
    checkOutput("wrap vec", vecOut[0], 32'hC7);
    observeWindow(0, 8, nRead, nWrite, nDone, firstDone);
    checkOutput("wrap done count", 32'(nDone), 32'd1);
    checkOutput("wrap extra read", 32'(nRead), 32'd0);

    // MEM_LAT=4: four read cycles, vector taken from the last one only.
    applyStimulus(2, 1'b0, 1'b1, 1'b0, 32'h1000);
    @(negedge clk);
    applyStimulus(2, 1'b0, 1'b0, 1'b0, 32'h1000);
    observeWindow(2, 10, nRead, nWrite, nDone, firstDone);
    checkOutput("lat4 read cycles", 32'(nRead), 32'd4);
    checkOutput("lat4 write cycles", 32'(nWrite), 32'd1);
    checkOutput("lat4 done count", 32'(nDone), 32'd1);
    checkOutput("lat4 done cycle", 32'(firstDone), 32'd6);
    checkOutput("lat4 vec", vecOut[2], 32'hA4);
    checkOutput("lat4 epc", epcOut[2], 32'h0FFC);

    // MEM_LAT=3: asynchronous reset in the middle of FETCH.
    applyStimulus(1, 1'b0, 1'b0, 1'b1, 32'h80);
    @(negedge clk);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h80);
    @(negedge clk);
    checkOutput("rst fetch read", 32'(memRead[1]), 32'd1);
    checkOutput("rst fetch addr", memAddr[1], 32'd255);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst async read", 32'(memRead[1]), 32'd0);
    checkOutput("rst async addr", memAddr[1], 32'd0);
    checkOutput("rst async epc", epcOut[1], 32'd0);
    checkOutput("rst async cause", 32'(excCause[1]), 32'd0);
    checkOutput("rst async active", 32'(excActive[1]), 32'd0);
    checkOutput("rst async write", 32'(pcWrite[1]), 32'd0);
    checkOutput("rst async sel", 32'(pcSrcSel[1]), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    observeWindow(1, 6, nRead, nWrite, nDone, firstDone);
    checkOutput("rst no write", 32'(nWrite), 32'd0);
    checkOutput("rst no read", 32'(nRead), 32'd0);
    checkOutput("rst stays idle", 32'(excActive[1]), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
